// File: rtl/fir_pkg.sv
// Shared types and constants for the sequenced FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT
  } state_t;

  localparam int MAC_LAT_DEF = 2;
  localparam int SHIFT_DEF   = 15;

  localparam logic signed [15:0] Q15_MAX = 16'sh7fff;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

endpackage

// File: rtl/q15_round_sat.sv
// Round-half-up, arithmetic shift and clamp of the
// wide accumulator down to a signed Q15 sample.
module q15_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W = 36,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [15:0]      q
);

  localparam logic signed [ACC_W:0] HALF =
    (ACC_W+1)'(1) << (SHIFT - 1);

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] sh;

  // one guard bit so the rounding add cannot wrap
  assign sum = {acc[ACC_W-1], acc} + HALF;
  assign sh  = sum >>> SHIFT;

  always_comb begin
    q = sh[15:0];
    if (sh > Q15_MAX) begin
      q = Q15_MAX;
    end else if (sh < Q15_MIN) begin
      q = Q15_MIN;
    end
  end

endmodule

// File: rtl/mac_fir_sequencer.sv
// Time-multiplexed FIR: streams coefficient/sample pairs
// into an external MAC16 and accumulates its products.
module mac_fir_sequencer
  import fir_pkg::*;
#(
  parameter  int NTAPS   = 16,
  parameter  int MAC_LAT = MAC_LAT_DEF,
  parameter  int SHIFT   = SHIFT_DEF,
  localparam int AW      = $clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [15:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [15:0]   out_data,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_waddr,
  input  logic signed [15:0]   coef_wdata,
  output logic                 busy,
  output logic signed [15:0]   mac_a,
  output logic signed [15:0]   mac_b,
  output logic                 mac_ce,
  input  logic signed [31:0]   mac_p
);

  localparam int ACC_W = 32 + AW;

  state_t                    state;
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             k;
  logic [AW-1:0]             rd_ptr;
  logic [7:0]                dcnt;
  logic [MAC_LAT-1:0]        vld;
  logic signed [ACC_W-1:0]   acc;
  logic signed [15:0]        rnd;
  logic signed [15:0]        coef [NTAPS];
  logic signed [15:0]        dl   [NTAPS];
  logic                      issue;

  // tap k walks backwards from the newest sample
  assign rd_ptr   = wr_ptr - AW'(1) - k;
  assign issue    = (state == RUN);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign mac_ce   = (state == RUN) || (state == DRAIN);
  assign mac_a    = issue ? coef[k] : '0;
  assign mac_b    = issue ? dl[rd_ptr] : '0;

  q15_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_rnd (
    .acc (acc),
    .q   (rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      k         <= '0;
      dcnt      <= '0;
      vld       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        coef[i] <= '0;
        dl[i]   <= '0;
      end
    end else if (clear) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      k         <= '0;
      dcnt      <= '0;
      vld       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        dl[i] <= '0;
      end
    end else begin
      vld <= MAC_LAT'({vld, issue});
      if (vld[MAC_LAT-1]) begin
        acc <= acc + {{AW{mac_p[31]}}, mac_p};
      end
      unique case (state)
        IDLE: begin
          if (coef_we) begin
            coef[coef_waddr] <= coef_wdata;
          end
          if (in_valid) begin
            dl[wr_ptr] <= in_data;
            wr_ptr     <= wr_ptr + AW'(1);
            k          <= '0;
            acc        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          k <= k + AW'(1);
          if (k == AW'(NTAPS - 1)) begin
            dcnt  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 8'd1;
          if (dcnt == 8'(MAC_LAT - 1)) begin
            state <= OUT;
          end
        end
        OUT: begin
          // last product lands on OUT entry; publish a cycle later
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= rnd;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
